mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles to wait for mem_ack before aborting a transfer.
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEADBEEF, read data returned on a timed-out read.
REQ-003 clk_rev  in  1  clock; all state updates on its rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 cpu_rd_req, cpu_wr_req  in  1 each  CPU read/write request; level, held until cpu_valid.
REQ-006 cpu_addr, cpu_wdata  in  32 each  CPU address / write data.
REQ-007 cpu_strb  in  3  CPU access size/sign code (Funct3 encoding).
REQ-008 cpu_valid  out  1  one-cycle completion pulse to CPU.
REQ-009 cpu_rdata  out  32  CPU read data; held until the next CPU read completes.
REQ-010 dma_rd_req, dma_wr_req, dma_addr, dma_wdata, dma_strb, dma_valid, dma_rdata: same widths and meaning for the DMA/loader port.
REQ-011 mem_rd, mem_wr  out  1 each  memory port strobes, registered.
REQ-012 mem_addr, mem_wdata  out  32 each; mem_strb  out  3; registered copies of the granted request.
REQ-013 mem_ack  in  1  memory completion; mem_rdata  in  32, valid when mem_ack=1.
REQ-014 err  out  1  one-cycle pulse with valid when a transfer timed out.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM IDLE, GNT_CPU, GNT_DMA, DONE.
REQ-017 IDLE: requester active = rd_req|wr_req; only CPU active -> GNT_CPU; only DMA active -> GNT_DMA; none -> stay.
REQ-018 Both active in IDLE SHALL grant the port not granted last (round-robin via last_gnt); last_gnt updated on each grant.
REQ-019 On grant edge: mem_addr/wdata/strb loaded from the winner; mem_wr=wr_req; mem_rd=rd_req & ~wr_req (rd+wr together = write); timeout counter cleared.
REQ-020 GNT_x: strobes held steady; mem_ack=1 -> DONE, strobes drop, read data latched into x_rdata if read, x_valid=1 for the DONE cycle.
REQ-021 GNT_x with counter reaching TIMEOUT and no mem_ack -> DONE, strobes drop, x_valid=1 and err=1; read returns ERR_DATA in x_rdata.
REQ-022 mem_ack and timeout on the same edge SHALL be treated as success (err=0).
REQ-023 DONE SHALL last exactly one cycle then go IDLE; requests are not sampled in DONE (lets requester drop its req after seeing valid).
REQ-024 Grant latency: request seen in IDLE -> strobes on next edge; a 1-cycle mem_ack gives valid 2 cycles after grant.
REQ-025 Non-granted requester SHALL be stalled (valid=0) with its request left pending; no request is dropped.
REQ-026 Changes to requester inputs while granted SHALL NOT affect the memory outputs.
REQ-027 mem_ack in IDLE or DONE SHALL be ignored.
REQ-028 Timeout counter SHALL be $clog2(TIMEOUT+1) bits and SHALL not wrap.

Reset
REQ-029 reset SHALL force IDLE; last_gnt=DMA (CPU wins first tie); all strobes, valid, err, busy = 0; rdata = 0; counter = 0.
REQ-030 reset mid-transfer SHALL abort immediately with no valid pulse; strobes drop the same instant.

Verification
REQ-031 CPU read 0x100, mem_ack 3 cycles after mem_rd, mem_rdata=0x12345678 -> cpu_valid 1 cycle, cpu_rdata=0x12345678, dma_valid=0, err=0.
REQ-032 CPU and DMA request in the same cycle after reset -> CPU granted first; DMA granted in the IDLE following CPU's DONE; next tie -> CPU (round-robin).
REQ-033 DMA write 0x200 data 0xA5A5A5A5 strb 3'b010 -> mem_wr=1, mem_addr=0x200, mem_wdata=0xA5A5A5A5 until ack; dma_rdata unchanged.
REQ-034 CPU read, mem_ack never asserted, TIMEOUT=4 -> after 4 cycles in GNT_CPU, cpu_valid=1, err=1, cpu_rdata=0xDEADBEEF, then IDLE.
REQ-035 Reset asserted in GNT_DMA -> mem_rd/mem_wr=0 asynchronously, no dma_valid; after release CPU wins a tie.
REQ-036 cpu_rd_req and cpu_wr_req both 1 -> write performed, mem_rd=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin CPU/DMA arbiter onto one memory port with ack timeout.
// Ports:
//   clk_rev, reset (async, active-high)
//   cpu_rd_req/cpu_wr_req/cpu_addr/cpu_wdata/cpu_strb -> cpu_valid/cpu_rdata
//   dma_rd_req/dma_wr_req/dma_addr/dma_wdata/dma_strb -> dma_valid/dma_rdata
//   mem_rd/mem_wr/mem_addr/mem_wdata/mem_strb (registered) <- mem_ack/mem_rdata
//   err (timeout pulse alongside valid), busy (not IDLE)
module mem_arbiter #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk_rev,
  input  logic        reset,
  input  logic        cpu_rd_req,
  input  logic        cpu_wr_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_strb,
  output logic        cpu_valid,
  output logic [31:0] cpu_rdata,
  input  logic        dma_rd_req,
  input  logic        dma_wr_req,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [2:0]  dma_strb,
  output logic        dma_valid,
  output logic [31:0] dma_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_strb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err,
  output logic        busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_DMA, DONE} state_t;
  state_t      state, state_n;
  logic        last_dma, last_dma_n;
  logic [CW-1:0] cnt, cnt_n;
  logic        rd_n, wr_n, cpu_valid_n, dma_valid_n, err_n;
  logic [31:0] addr_n, wdata_n, cpu_rdata_n, dma_rdata_n, rsel;
  logic [2:0]  strb_n;
  logic        cpu_act, dma_act, pick_dma, timeout, finish;
  assign cpu_act  = cpu_rd_req | cpu_wr_req;
  assign dma_act  = dma_rd_req | dma_wr_req;
  // DMA wins only when CPU is idle, or on a tie when CPU was granted last
  assign pick_dma = dma_act & (~cpu_act | ~last_dma);
  // cnt counts completed wait cycles; the next miss is the TIMEOUT-th one
  assign timeout  = cnt == CW'(TIMEOUT - 1);
  assign finish   = mem_ack | timeout;
  assign rsel     = mem_ack ? mem_rdata : ERR_DATA;
  assign busy     = state != IDLE;
  always_comb begin
    state_n     = state;
    last_dma_n  = last_dma;
    cnt_n       = cnt;
    rd_n        = mem_rd;
    wr_n        = mem_wr;
    addr_n      = mem_addr;
    wdata_n     = mem_wdata;
    strb_n      = mem_strb;
    cpu_valid_n = 1'b0;
    dma_valid_n = 1'b0;
    err_n       = 1'b0;
    cpu_rdata_n = cpu_rdata;
    dma_rdata_n = dma_rdata;
    case (state)
      IDLE: if (cpu_act | dma_act) begin
        state_n    = pick_dma ? GNT_DMA : GNT_CPU;
        last_dma_n = pick_dma;
        cnt_n      = '0;
        addr_n     = pick_dma ? dma_addr : cpu_addr;
        wdata_n    = pick_dma ? dma_wdata : cpu_wdata;
        strb_n     = pick_dma ? dma_strb : cpu_strb;
        wr_n       = pick_dma ? dma_wr_req : cpu_wr_req;
        rd_n       = pick_dma ? dma_rd_req & ~dma_wr_req : cpu_rd_req & ~cpu_wr_req;
      end
      GNT_CPU, GNT_DMA: if (finish) begin
        state_n     = DONE;
        rd_n        = 1'b0;
        wr_n        = 1'b0;
        err_n       = ~mem_ack;
        cpu_valid_n = state == GNT_CPU;
        dma_valid_n = state == GNT_DMA;
        cpu_rdata_n = (state == GNT_CPU && mem_rd) ? rsel : cpu_rdata;
        dma_rdata_n = (state == GNT_DMA && mem_rd) ? rsel : dma_rdata;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_rev or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last_dma  <= 1'b1;
      cnt       <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_strb  <= '0;
      cpu_valid <= 1'b0;
      dma_valid <= 1'b0;
      err       <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      state     <= state_n;
      last_dma  <= last_dma_n;
      cnt       <= cnt_n;
      mem_rd    <= rd_n;
      mem_wr    <= wr_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      mem_strb  <= strb_n;
      cpu_valid <= cpu_valid_n;
      dma_valid <= dma_valid_n;
      err       <= err_n;
      cpu_rdata <= cpu_rdata_n;
      dma_rdata <= dma_rdata_n;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  localparam int TO = 4;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;
  logic clk_rev = 0, reset = 1;
  logic cpu_rd_req = 0, cpu_wr_req = 0, dma_rd_req = 0, dma_wr_req = 0, mem_ack = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0, mem_rdata = 0;
  logic [2:0] cpu_strb = 0, dma_strb = 0;
  logic cpu_valid, dma_valid, mem_rd, mem_wr, err, busy;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic [2:0] mem_strb;
  int errors = 0, checks = 0;
  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk_rev(clk_rev), .reset(reset),
    .cpu_rd_req(cpu_rd_req), .cpu_wr_req(cpu_wr_req), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_strb(cpu_strb), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
    .dma_rd_req(dma_rd_req), .dma_wr_req(dma_wr_req), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_strb(dma_strb), .dma_valid(dma_valid), .dma_rdata(dma_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_strb(mem_strb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err), .busy(busy)
  );
  always #5 clk_rev = ~clk_rev;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk_rev);
    #1;
  endtask
  // Transaction-level model: phase 0 idle, 1 transfer outstanding, 2 completion cycle
  int phase, who, waited;
  bit last_dma, m_rd, m_wr, m_err;
  bit m_valid [2];
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata [2];
  logic [2:0] m_strb;
  task automatic model_reset;
    phase = 0; who = 0; waited = 0; last_dma = 1; m_rd = 0; m_wr = 0; m_err = 0;
    m_valid[0] = 0; m_valid[1] = 0; m_addr = 0; m_wdata = 0; m_strb = 0;
    m_rdata[0] = 0; m_rdata[1] = 0;
  endtask
  task automatic model_step;
    bit c, d;
    c = cpu_rd_req | cpu_wr_req;
    d = dma_rd_req | dma_wr_req;
    m_valid[0] = 0; m_valid[1] = 0; m_err = 0;
    if (phase == 0 && (c || d)) begin
      who = (c && d) ? int'(!last_dma) : int'(d);
      last_dma = who == 1;
      m_addr  = who ? dma_addr : cpu_addr;
      m_wdata = who ? dma_wdata : cpu_wdata;
      m_strb  = who ? dma_strb : cpu_strb;
      m_wr    = who ? dma_wr_req : cpu_wr_req;
      m_rd    = !m_wr;
      waited  = 0;
      phase   = 1;
    end else if (phase == 1) begin
      waited++;
      if (mem_ack || waited == TO) begin
        phase = 2;
        m_err = !mem_ack;
        m_valid[who] = 1;
        if (m_rd) m_rdata[who] = mem_ack ? mem_rdata : ERRD;
      end
    end else if (phase == 2) phase = 0;
  endtask
  initial begin
    model_reset;
    forever begin
      @(negedge clk_rev);
      if (reset) model_reset;
      chk("busy", busy, phase != 0);
      chk("mem_rd", mem_rd, phase == 1 && m_rd);
      chk("mem_wr", mem_wr, phase == 1 && m_wr);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_strb", mem_strb, m_strb);
      chk("cpu_valid", cpu_valid, m_valid[0]);
      chk("dma_valid", dma_valid, m_valid[1]);
      chk("err", err, m_err);
      chk("cpu_rdata", cpu_rdata, m_rdata[0]);
      chk("dma_rdata", dma_rdata, m_rdata[1]);
      if (!reset) model_step;
    end
  end
  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {mem_rd, mem_wr}, 0);
    chk("rst_valid_err", {cpu_valid, dma_valid, err}, 0);
    tick; tick; reset = 0;
    // simultaneous requests after reset: CPU first, then DMA, then CPU again
    cpu_wr_req = 1; cpu_addr = 32'h40; cpu_wdata = 32'h11; cpu_strb = 3'b010;
    dma_rd_req = 1; dma_addr = 32'h80; dma_strb = 3'b010;
    tick;
    chk("tie1_wr", mem_wr, 1);
    chk("tie1_addr", mem_addr, 32'h40);
    mem_ack = 1; tick;
    chk("tie1_cpu_valid", cpu_valid, 1);
    chk("tie1_dma_stall", dma_valid, 0);
    cpu_wr_req = 0; mem_ack = 0; tick;
    chk("done_to_idle", busy, 0);
    tick;
    chk("tie1_dma_rd", mem_rd, 1);
    chk("tie1_dma_addr", mem_addr, 32'h80);
    mem_ack = 1; mem_rdata = 32'h0BADF00D; tick;
    chk("tie1_dma_rdata", dma_rdata, 32'h0BADF00D);
    dma_rd_req = 0; mem_ack = 0; tick;
    cpu_rd_req = 1; dma_rd_req = 1; tick;
    chk("tie2_cpu_addr", mem_addr, 32'h40);
    mem_ack = 1; mem_rdata = 0; tick;
    cpu_rd_req = 0; mem_ack = 0; tick; tick;
    chk("tie2_dma_addr", mem_addr, 32'h80);
    mem_ack = 1; mem_rdata = 32'h0BADF00D; tick;
    dma_rd_req = 0; mem_ack = 0; tick;
    // CPU read with ack three cycles after the strobe
    cpu_rd_req = 1; cpu_addr = 32'h100; tick;
    chk("rd_strobe", mem_rd, 1);
    chk("rd_addr", mem_addr, 32'h100);
    tick; tick;
    mem_ack = 1; mem_rdata = 32'h12345678; tick;
    chk("rd_valid", cpu_valid, 1);
    chk("rd_data", cpu_rdata, 32'h12345678);
    chk("rd_no_dma", dma_valid, 0);
    chk("rd_no_err", err, 0);
    cpu_rd_req = 0; mem_ack = 0; tick;
    // DMA write; input changes while granted must not reach the memory port
    dma_wr_req = 1; dma_addr = 32'h200; dma_wdata = 32'hA5A5A5A5; dma_strb = 3'b010; tick;
    chk("wr_strobe", mem_wr, 1);
    chk("wr_addr", mem_addr, 32'h200);
    chk("wr_strb", mem_strb, 3'b010);
    dma_wdata = 0; dma_addr = 32'h999; tick;
    chk("wr_hold_data", mem_wdata, 32'hA5A5A5A5);
    mem_ack = 1; tick;
    chk("wr_valid", dma_valid, 1);
    chk("wr_rdata_kept", dma_rdata, 32'h0BADF00D);
    dma_wr_req = 0; mem_ack = 0; tick;
    // read and write together is a write
    cpu_rd_req = 1; cpu_wr_req = 1; tick;
    chk("rdwr_wr", mem_wr, 1);
    chk("rdwr_rd", mem_rd, 0);
    mem_ack = 1; mem_rdata = 32'h5555AAAA; tick;
    chk("rdwr_rdata_kept", cpu_rdata, 32'h12345678);
    cpu_rd_req = 0; cpu_wr_req = 0; mem_ack = 0; tick;
    // timeout: ack never comes
    cpu_rd_req = 1; tick; tick; tick; tick;
    chk("to_wait_valid", cpu_valid, 0);
    chk("to_wait_busy", busy, 1);
    tick;
    chk("to_valid", cpu_valid, 1);
    chk("to_err", err, 1);
    chk("to_data", cpu_rdata, ERRD);
    cpu_rd_req = 0; tick;
    chk("to_idle", busy, 0);
    // reset during a DMA transfer
    dma_rd_req = 1; tick;
    chk("rst_mid_rd", mem_rd, 1);
    #2 reset = 1;
    #1;
    chk("rst_mid_strobe", mem_rd, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", dma_valid, 0);
    cpu_rd_req = 1; tick; reset = 0; tick;
    chk("rst_tie_cpu", mem_addr, 32'h100);
    mem_ack = 1; tick;
    cpu_rd_req = 0; mem_ack = 0; tick; tick;
    mem_ack = 1; tick;
    dma_rd_req = 0; mem_ack = 0; tick;
    // randomized traffic with a random-latency memory
    for (int i = 0; i < 3000; i++) begin
      tick;
      if (reset) reset = 0;
      else if ($urandom_range(0, 299) == 0) reset = 1;
      mem_ack = (mem_rd | mem_wr) ? $urandom_range(0, 3) == 0 : $urandom_range(0, 7) == 0;
      mem_rdata = $urandom;
      cpu_addr = $urandom; cpu_wdata = $urandom; cpu_strb = 3'($urandom);
      dma_addr = $urandom; dma_wdata = $urandom; dma_strb = 3'($urandom);
      if (cpu_valid) {cpu_wr_req, cpu_rd_req} = 0;
      else if (!(cpu_rd_req | cpu_wr_req) && $urandom_range(0, 2) == 0)
        {cpu_wr_req, cpu_rd_req} = 2'($urandom_range(1, 3));
      if (dma_valid) {dma_wr_req, dma_rd_req} = 0;
      else if (!(dma_rd_req | dma_wr_req) && $urandom_range(0, 2) == 0)
        {dma_wr_req, dma_rd_req} = 2'($urandom_range(1, 3));
    end
    tick; tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
